// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the full iteration count N, not just N-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division iteration: shift in a bit, trial-subtract, restore on borrow.
module restoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_o
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] t;

  // The partial remainder entering a step is always below the divisor, so its
  // extra top bit is zero and only the low WIDTH bits need to be carried.
  assign r_sh = {r_i, bit_i};
  assign t    = r_sh - {1'b0, divisor_i};
  assign q_o  = ~t[WIDTH];
  assign r_o  = t[WIDTH] ? r_sh[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/restoring_divider_seq.sv
// Fixed-point unsigned divider, one quotient bit per clock; start accepted only when idle,
// results registered and held from the done pulse until the next accepted start.
module restoring_divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       dividend,
  input  logic [WIDTH-1:0]       divisor,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH+FRAC_BITS-1:0] quotient,
  output logic [WIDTH-1:0]       remainder,
  output logic                   div_by_zero
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = cnt_width(N);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   e_q, e_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [N-2:0]   qsr_q, qsr_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [WIDTH-1:0] step_r;
  logic             step_q;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .r_i       (r_q),
    .bit_i     (e_q[N-1]),
    .divisor_i (dvs_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    r_d     = r_q;
    qsr_d   = qsr_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d = divisor;
          e_d   = N'(dividend) << FRAC_BITS;
          r_d   = '0;
          qsr_d = '0;
          cnt_d = CW'(N);
          quo_d = '0;
          rem_d = '0;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
            cnt_d   = '0;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        e_d   = e_q << 1;
        r_d   = step_r;
        // Only N-1 bits are kept; the final bit goes straight into the result.
        qsr_d = (N-1)'({qsr_q, step_q});
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = {qsr_q, step_q};
          rem_d   = step_r;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      e_q     <= '0;
      r_q     <= '0;
      qsr_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      r_q     <= r_d;
      qsr_q   <= qsr_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
